// File: rtl/address_pkg.sv
// Shared codes for the 6502 operand-address path: select codes (address_mux), mode codes (decoder), sequencer states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package address_pkg;

  // address_mux select codes
  localparam logic [2:0] ADDR_SEL_PC   = 3'b000;  // PC
  localparam logic [2:0] ADDR_SEL_ZP   = 3'b001;  // {00, dirl}
  localparam logic [2:0] ADDR_SEL_ABS  = 3'b010;  // {dirh, dirl}
  localparam logic [2:0] ADDR_SEL_IND  = 3'b011;  // {00, indirl}
  localparam logic [2:0] ADDR_SEL_IND1 = 3'b100;  // {00, indirl+1}, wraps inside page 00

  // decoder addressing-mode codes
  localparam logic [1:0] MODE_IMM = 2'b00;
  localparam logic [1:0] MODE_ZP  = 2'b01;
  localparam logic [1:0] MODE_ABS = 2'b10;
  localparam logic [1:0] MODE_IND = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH_LO = 3'd1,
    ST_FETCH_HI = 3'd2,
    ST_PTR_LO   = 3'd3,
    ST_PTR_HI   = 3'd4,
    ST_DONE     = 3'd5
  } seq_state_t;

endpackage

// File: rtl/address_sequencer.sv
// Addressing-mode sequencer: fetches operand/pointer bytes and steers address_mux for one operand request.
// Latency: start edge to done cycle IMM 1, ZP 2, ABS 3, IND 4 cycles, plus one per rdy=0 cycle.
// Backpressure: rdy=0 freezes state and byte registers and suppresses pc_inc; start is only taken in IDLE/DONE.
// Ports: clk, reset_n (async low); rdy, start, mode[1:0], data_in[7:0] in;
//        address_select[2:0], dirl, dirh, indirl, indirh[7:0], pc_inc, busy, done out.
module address_sequencer
  import address_pkg::*;
#(
  parameter bit IMM_PC_INC = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rdy,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic [7:0] data_in,
  output logic [2:0] address_select,
  output logic [7:0] dirl,
  output logic [7:0] dirh,
  output logic [7:0] indirl,
  output logic [7:0] indirh,
  output logic       pc_inc,
  output logic       busy,
  output logic       done
);

  seq_state_t state;
  logic [1:0] mode_q;
  logic       pc_step;

  // Zero-page pointers never carry into a high byte; the port exists only for address_mux.
  assign indirh = 8'h00;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      mode_q <= MODE_IMM;
      dirl   <= 8'h00;
      dirh   <= 8'h00;
      indirl <= 8'h00;
    end else if (rdy) begin
      case (state)
        ST_IDLE, ST_DONE: begin
          // DONE accepts a new request directly so back-to-back operands keep busy high.
          if (start) begin
            mode_q <= mode;
            state  <= (mode == MODE_IMM) ? ST_DONE : ST_FETCH_LO;
          end else begin
            state  <= ST_IDLE;
          end
        end
        ST_FETCH_LO: begin
          if (mode_q == MODE_IND) begin
            indirl <= data_in;
            state  <= ST_PTR_LO;
          end else begin
            dirl  <= data_in;
            state <= (mode_q == MODE_ZP) ? ST_DONE : ST_FETCH_HI;
          end
        end
        ST_FETCH_HI: begin
          dirh  <= data_in;
          state <= ST_DONE;
        end
        ST_PTR_LO: begin
          dirl  <= data_in;
          state <= ST_PTR_HI;
        end
        ST_PTR_HI: begin
          dirh  <= data_in;
          state <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Moore decode of the state register; only pc_inc looks at rdy so PC never moves on a stalled cycle.
  always_comb begin
    address_select = ADDR_SEL_PC;
    pc_step        = 1'b0;
    busy           = 1'b1;
    done           = 1'b0;
    case (state)
      ST_IDLE:     busy = 1'b0;
      ST_FETCH_LO: pc_step = 1'b1;
      ST_FETCH_HI: pc_step = 1'b1;
      ST_PTR_LO:   address_select = ADDR_SEL_IND;
      ST_PTR_HI:   address_select = ADDR_SEL_IND1;
      ST_DONE: begin
        done = 1'b1;
        case (mode_q)
          MODE_IMM: begin
            address_select = ADDR_SEL_PC;
            pc_step        = IMM_PC_INC;
          end
          MODE_ZP: address_select = ADDR_SEL_ZP;
          default: address_select = ADDR_SEL_ABS;
        endcase
      end
      default: busy = 1'b0;
    endcase
  end

  assign pc_inc = pc_step & rdy;

endmodule

// File: tb/tb_address_sequencer.sv
// Directed bench for address_sequencer: ZP, ABS, IND (page wrap), stalls, back-to-back, ignored start, mid-sequence reset.
// Latency: inputs driven 1 time unit after each rising edge, outputs checked 2 units after it.
// Backpressure: rdy is driven low on chosen cycles to exercise stalls.
module tb_address_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       rdy;
  logic       start;
  logic [1:0] mode;
  logic [7:0] data_in;
  logic [2:0] address_select;
  logic [7:0] dirl, dirh, indirl, indirh;
  logic       pc_inc, busy, done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  address_sequencer #(.IMM_PC_INC(1'b1)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .rdy            (rdy),
    .start          (start),
    .mode           (mode),
    .data_in        (data_in),
    .address_select (address_select),
    .dirl           (dirl),
    .dirh           (dirh),
    .indirl         (indirl),
    .indirh         (indirh),
    .pc_inc         (pc_inc),
    .busy           (busy),
    .done           (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after driving inputs.
  task automatic settle();
    #1;
  endtask

  initial begin
    reset_n = 1'b0; rdy = 1'b1; start = 1'b0; mode = 2'b00; data_in = 8'h00;
    #2;
    chk("rst_sel", address_select, 3'b000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_pcinc", pc_inc, 1'b0);
    chk("rst_regs", {dirh, dirl, indirh, indirl}, 32'h0);
    step(); step();
    reset_n = 1'b1;

    // ---- ZP: operand 42 ----
    step(); start = 1'b1; mode = 2'b01; settle();
    chk("zp_idle_busy", busy, 1'b0);
    step(); start = 1'b0; data_in = 8'h42; settle();
    chk("zp_flo_sel", address_select, 3'b000);
    chk("zp_flo_pcinc", pc_inc, 1'b1);
    chk("zp_flo_busy_done", {busy, done}, 2'b10);
    step(); settle();
    chk("zp_done", done, 1'b1);
    chk("zp_done_sel", address_select, 3'b001);
    chk("zp_dirl", dirl, 8'h42);
    chk("zp_done_pcinc", pc_inc, 1'b0);
    step(); settle();
    chk("zp_back_idle", {busy, done}, 2'b00);

    // ---- ABS: bytes 34, 12 ----
    start = 1'b1; mode = 2'b10;
    step(); start = 1'b0; data_in = 8'h34; settle();
    chk("abs_flo", {address_select, pc_inc}, {3'b000, 1'b1});
    step(); data_in = 8'h12; settle();
    chk("abs_fhi", {address_select, pc_inc}, {3'b000, 1'b1});
    chk("abs_fhi_dirl", dirl, 8'h34);
    step(); settle();
    chk("abs_done", {done, address_select}, {1'b1, 3'b010});
    chk("abs_addr", {dirh, dirl}, 16'h1234);
    step(); settle();

    // ---- IND with page wrap: operand FF, mem[00FF]=78, mem[0000]=56 ----
    start = 1'b1; mode = 2'b11;
    step(); start = 1'b0; data_in = 8'hFF; settle();
    chk("ind_flo", {address_select, pc_inc}, {3'b000, 1'b1});
    step(); data_in = 8'h78; settle();
    chk("ind_plo", {address_select, pc_inc}, {3'b011, 1'b0});
    chk("ind_indirl", indirl, 8'hFF);
    step(); data_in = 8'h56; settle();
    chk("ind_phi", {address_select, pc_inc}, {3'b100, 1'b0});
    chk("ind_phi_dirl", dirl, 8'h78);
    step(); settle();
    chk("ind_done", {done, address_select}, {1'b1, 3'b010});
    chk("ind_addr", {dirh, dirl}, 16'h5678);
    chk("ind_ptr", {indirh, indirl}, 16'h00FF);
    step(); settle();

    // ---- ABS with 2-cycle stall in FETCH_HI; mode changed after acceptance ----
    start = 1'b1; mode = 2'b10;
    step(); start = 1'b0; mode = 2'b00; data_in = 8'h21; settle();
    chk("stl_flo_pcinc", pc_inc, 1'b1);
    step(); rdy = 1'b0; data_in = 8'h99; settle();
    chk("stl_fhi1_pcinc", pc_inc, 1'b0);
    step(); settle();
    chk("stl_fhi2_pcinc", pc_inc, 1'b0);
    chk("stl_dirh_held", dirh, 8'h56);
    chk("stl_still_busy", {busy, done}, 2'b10);
    step(); rdy = 1'b1; data_in = 8'h43; settle();
    chk("stl_fhi3_pcinc", pc_inc, 1'b1);
    step(); rdy = 1'b0; settle();
    chk("stl_done", {done, address_select}, {1'b1, 3'b010});
    chk("stl_addr", {dirh, dirl}, 16'h4321);
    step(); settle();
    chk("stl_done_hold", {done, address_select}, {1'b1, 3'b010});
    rdy = 1'b1;
    step(); settle();
    chk("stl_idle", busy, 1'b0);

    // ---- IMM, then back-to-back ZP from DONE with ignored start in FETCH_LO ----
    start = 1'b1; mode = 2'b00;
    step(); mode = 2'b01; settle();
    chk("imm_done", {done, address_select, pc_inc}, {1'b1, 3'b000, 1'b1});
    step(); mode = 2'b10; data_in = 8'h55; settle();
    chk("b2b_flo", {busy, done, pc_inc}, 3'b101);
    step(); start = 1'b0; settle();
    chk("b2b_zp_done", {done, address_select}, {1'b1, 3'b001});
    chk("b2b_zp_dirl", dirl, 8'h55);
    chk("b2b_zp_dirh_kept", dirh, 8'h43);
    step(); settle();
    chk("b2b_idle", busy, 1'b0);

    // ---- reset in PTR_LO, then a clean ZP ----
    start = 1'b1; mode = 2'b11;
    step(); start = 1'b0; data_in = 8'h0A; settle();
    step(); settle();
    chk("rst2_in_plo", address_select, 3'b011);
    reset_n = 1'b0; settle();
    chk("rst2_outs", {address_select, pc_inc, busy, done}, 6'b0);
    chk("rst2_regs", {dirh, dirl, indirh, indirl}, 32'h0);
    step(); reset_n = 1'b1; settle();
    start = 1'b1; mode = 2'b01;
    step(); start = 1'b0; data_in = 8'h07; settle();
    chk("post_flo", {busy, pc_inc}, 2'b11);
    step(); settle();
    chk("post_done", {done, address_select}, {1'b1, 3'b001});
    chk("post_regs", {dirh, dirl, indirl}, 24'h00_07_00);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
